// File: rtl/brush_rasterizer.sv
// Paint engine: expands point / square-brush / clear commands into a raster-ordered
// stream of single-pixel writes with store back-pressure. All outputs are registered.
module brush_rasterizer #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int CW        = 3,
    parameter int MAX_BRUSH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [CW-1:0] cmd_color,
    input  logic [3:0]    cmd_size,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [CW-1:0] wr_color,
    input  logic          wr_stall,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [1:0]    OP_POINT  = 2'b00;
    localparam logic [1:0]    OP_SQUARE = 2'b01;
    localparam logic [1:0]    OP_CLEAR  = 2'b10;
    localparam logic [1:0]    OP_NOP    = 2'b11;
    localparam logic [XW-1:0] X_MAX     = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(V_ACTIVE - 1);
    localparam logic [3:0]    MAX_SIDE  = 4'(MAX_BRUSH);

    // Effective brush side: 0 paints a single pixel, oversize saturates.
    function automatic logic [3:0] eff_side(input logic [3:0] size);
        logic [3:0] side;
        if (size == 4'd0) begin
            side = 4'd1;
        end else if (size > MAX_SIDE) begin
            side = MAX_SIDE;
        end else begin
            side = size;
        end
        return side;
    endfunction

    // The (XW+2)-bit difference is two's complement, so its top bit flags a negative start.
    function automatic logic [XW-1:0] clip_x_lo(input logic [XW-1:0] c, input logic [3:0] side);
        logic [XW+1:0] lo;
        lo = {2'b00, c} - {{(XW-2){1'b0}}, 1'b0, side[3:1]};
        if (lo[XW+1]) begin
            return '0;
        end else begin
            return lo[XW-1:0];
        end
    endfunction

    function automatic logic [XW-1:0] clip_x_hi(input logic [XW-1:0] c, input logic [3:0] side);
        logic [XW+1:0] hi;
        hi = {2'b00, c} - {{(XW-2){1'b0}}, 1'b0, side[3:1]}
             + {{(XW-2){1'b0}}, side} - {{(XW+1){1'b0}}, 1'b1};
        if (hi > {2'b00, X_MAX}) begin
            return X_MAX;
        end else begin
            return hi[XW-1:0];
        end
    endfunction

    function automatic logic [YW-1:0] clip_y_lo(input logic [YW-1:0] c, input logic [3:0] side);
        logic [YW+1:0] lo;
        lo = {2'b00, c} - {{(YW-2){1'b0}}, 1'b0, side[3:1]};
        if (lo[YW+1]) begin
            return '0;
        end else begin
            return lo[YW-1:0];
        end
    endfunction

    function automatic logic [YW-1:0] clip_y_hi(input logic [YW-1:0] c, input logic [3:0] side);
        logic [YW+1:0] hi;
        hi = {2'b00, c} - {{(YW-2){1'b0}}, 1'b0, side[3:1]}
             + {{(YW-2){1'b0}}, side} - {{(YW+1){1'b0}}, 1'b1};
        if (hi > {2'b00, Y_MAX}) begin
            return Y_MAX;
        end else begin
            return hi[YW-1:0];
        end
    endfunction

    state_t        state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          wr_en_q, wr_en_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [CW-1:0] wr_color_q, wr_color_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [XW-1:0] x1_q, x1_d;
    logic [YW-1:0] y1_q, y1_d;

    logic          reject_s;
    logic [3:0]    side_s;
    logic [XW-1:0] win_x0_s, win_x1_s;
    logic [YW-1:0] win_y0_s, win_y1_s;

    // Window of the command currently offered on the cmd_* inputs.
    always_comb begin
        side_s   = eff_side(cmd_size);
        reject_s = 1'b0;
        win_x0_s = '0;
        win_x1_s = '0;
        win_y0_s = '0;
        win_y1_s = '0;
        case (cmd_op)
            OP_POINT: begin
                reject_s = (cmd_x > X_MAX) || (cmd_y > Y_MAX);
                win_x0_s = cmd_x;
                win_x1_s = cmd_x;
                win_y0_s = cmd_y;
                win_y1_s = cmd_y;
            end
            OP_SQUARE: begin
                reject_s = (cmd_x > X_MAX) || (cmd_y > Y_MAX);
                win_x0_s = clip_x_lo(cmd_x, side_s);
                win_x1_s = clip_x_hi(cmd_x, side_s);
                win_y0_s = clip_y_lo(cmd_y, side_s);
                win_y1_s = clip_y_hi(cmd_y, side_s);
            end
            OP_CLEAR: begin
                win_x1_s = X_MAX;
                win_y1_s = Y_MAX;
            end
            default: begin
                reject_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic; outputs are computed one edge ahead.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        wr_en_d     = wr_en_q;
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        wr_color_d  = wr_color_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                wr_en_d     = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (cmd_op == OP_NOP) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else if (reject_s) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_DRAW;
                        wr_en_d    = 1'b1;
                        wr_x_d     = win_x0_s;
                        wr_y_d     = win_y0_s;
                        wr_color_d = cmd_color;
                        x0_d       = win_x0_s;
                        x1_d       = win_x1_s;
                        y1_d       = win_y1_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAW: begin
                // A stalled write keeps every write output frozen.
                if (!wr_stall) begin
                    if (wr_x_q == x1_q) begin
                        if (wr_y_q == y1_q) begin
                            state_d = ST_FINISH;
                            wr_en_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            wr_x_d = x0_q;
                            wr_y_d = wr_y_q + {{(YW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        wr_x_d = wr_x_q + {{(XW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_FINISH: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                wr_en_d     = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                wr_en_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_color_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            wr_color_q  <= wr_color_d;
            done_q      <= done_d;
            err_q       <= err_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign wr_en     = wr_en_q;
    assign wr_x      = wr_x_q;
    assign wr_y      = wr_y_q;
    assign wr_color  = wr_color_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_brush_rasterizer.sv
// Bench for brush_rasterizer on an 80x60 screen: a pixel-list model checked every cycle
// plus per-command literal expectations (write count, first/last pixel, done cycle, err).
module tb_brush_rasterizer;

    localparam int H  = 80;
    localparam int V  = 60;
    localparam int MB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [9:0] cmd_x = 10'd0;
    logic [9:0] cmd_y = 10'd0;
    logic [2:0] cmd_color = 3'd0;
    logic [3:0] cmd_size = 4'd0;
    logic       wr_en;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [2:0] wr_color;
    logic       wr_stall = 1'b0;
    logic       busy;
    logic       done;
    logic       err;

    brush_rasterizer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .XW(10), .YW(10), .CW(3), .MAX_BRUSH(MB)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_size(cmd_size),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_stall(wr_stall),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state, owned by the compare process.
    int qx[$];
    int qy[$];
    bit armed = 1'b0;
    bit m_ready = 1'b1;
    bit m_done = 1'b0;
    bit m_err = 1'b0;
    bit m_rst_vals = 1'b0;
    int m_color = 0;
    int n_taken = 0;
    int n_stall = 0;
    int cmd_takes = 0;
    int tk_fx = 0, tk_fy = 0, tk_lx = 0, tk_ly = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Pixel list of a command: every screen pixel inside the brush box, in raster order.
    task automatic model_accept(input int op, input int x, input int y, input int c, input int sz,
                                output bit rej);
        int s, lx, hx, ly, hy;
        rej = 1'b0;
        qx.delete();
        qy.delete();
        if (op == 3) return;
        if (op != 2 && (x >= H || y >= V)) begin
            rej = 1'b1;
            return;
        end
        if (op == 0) begin
            lx = x; hx = x; ly = y; hy = y;
        end else if (op == 1) begin
            s  = (sz == 0) ? 1 : ((sz > MB) ? MB : sz);
            lx = x - s / 2; hx = lx + s - 1;
            ly = y - s / 2; hy = ly + s - 1;
        end else begin
            lx = 0; hx = H - 1; ly = 0; hy = V - 1;
        end
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                if (xx >= lx && xx <= hx && yy >= ly && yy <= hy) begin
                    qx.push_back(xx);
                    qy.push_back(yy);
                end
        m_color = c;
    endtask

    // Compare process: checks outputs every cycle, then advances the model.
    initial begin
        bit rej, nd;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (armed) begin
                check("cmd_ready", cmd_ready, m_ready);
                check("busy", busy, !m_ready);
                check("done", done, m_done);
                check("err", err, m_done && m_err);
                if (qx.size() > 0) begin
                    check("wr_en", wr_en, 1);
                    check("wr_x", wr_x, qx[0]);
                    check("wr_y", wr_y, qy[0]);
                    check("wr_color", wr_color, m_color);
                end else begin
                    check("wr_en_idle", wr_en, 0);
                    if (m_rst_vals) begin
                        check("rst_wr_x", wr_x, 0);
                        check("rst_wr_y", wr_y, 0);
                        check("rst_wr_color", wr_color, 0);
                    end
                end
            end
            if (reset) begin
                armed = 1'b1;
                m_ready = 1'b1;
                m_done = 1'b0;
                m_err = 1'b0;
                m_rst_vals = 1'b1;
                qx.delete();
                qy.delete();
            end else if (armed) begin
                m_rst_vals = 1'b0;
                nd = 1'b0;
                if (m_done) begin
                    m_ready = 1'b1;
                end else if (qx.size() > 0) begin
                    if (!wr_stall) begin
                        if (cmd_takes == 0) begin
                            tk_fx = wr_x; tk_fy = wr_y;
                        end
                        tk_lx = wr_x; tk_ly = wr_y;
                        cmd_takes++;
                        n_taken++;
                        void'(qx.pop_front());
                        void'(qy.pop_front());
                        if (qx.size() == 0) begin
                            nd = 1'b1;
                            m_err = 1'b0;
                        end
                    end else begin
                        n_stall++;
                    end
                end else if (m_ready && cmd_valid) begin
                    m_ready = 1'b0;
                    cmd_takes = 0;
                    model_accept(cmd_op, cmd_x, cmd_y, cmd_color, cmd_size, rej);
                    if (qx.size() == 0) begin
                        nd = 1'b1;
                        m_err = rej;
                    end
                end
                m_done = nd;
            end
        end
    end

    // Issue one command and check its literal outcome; stall_pct applies per cycle.
    task automatic run_cmd(input string nm, input logic [1:0] op, input int x, input int y,
                           input int c, input int sz, input int stall_pct, input int exp_n,
                           input int exp_err, input int fx, input int fy, input int lx, input int ly);
        int t0n, t0s, k;
        bit got;
        @(negedge clk);
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_x = 10'(x);
        cmd_y = 10'(y);
        cmd_color = 3'(c);
        cmd_size = 4'(sz);
        wr_stall = 1'b0;
        t0n = n_taken;
        t0s = n_stall;
        got = 1'b0;
        for (int i = 1; i < 20000 && !got; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            wr_stall = ($urandom_range(99) < stall_pct);
            #2;
            if (done) begin
                got = 1'b1;
                check({nm, "_writes"}, n_taken - t0n, exp_n);
                check({nm, "_done_cycle"}, i, exp_n + 1 + (n_stall - t0s));
                check({nm, "_err"}, err, exp_err);
                if (exp_n > 0) begin
                    check({nm, "_first_x"}, tk_fx, fx);
                    check({nm, "_first_y"}, tk_fy, fy);
                    check({nm, "_last_x"}, tk_lx, lx);
                    check({nm, "_last_y"}, tk_ly, ly);
                end
            end
        end
        wr_stall = 1'b0;
        if (!got) check({nm, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        int t0n;
        bit hit;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_wr_en", wr_en, 0);

        run_cmd("point",     2'b00, 10, 20, 5, 0,  0, 1,    0, 10, 20, 10, 20);
        run_cmd("square3",   2'b01, 50, 40, 3, 3,  0, 9,    0, 49, 39, 51, 41);
        run_cmd("sq4_origin",2'b01, 0,  0,  4, 4,  0, 4,    0, 0,  0,  1,  1);
        run_cmd("sq8_corner",2'b01, 79, 59, 6, 8,  0, 25,   0, 75, 55, 79, 59);
        run_cmd("sq0",       2'b01, 30, 30, 7, 0,  0, 1,    0, 30, 30, 30, 30);
        run_cmd("sq15",      2'b01, 40, 30, 1, 15, 0, 64,   0, 36, 26, 43, 33);
        run_cmd("point_x80", 2'b00, 80, 5,  2, 0,  0, 0,    1, 0,  0,  0,  0);
        run_cmd("sq_y60",    2'b01, 5,  60, 2, 3,  0, 0,    1, 0,  0,  0,  0);
        run_cmd("noop",      2'b11, 0,  0,  0, 0,  0, 0,    0, 0,  0,  0,  0);
        run_cmd("sq3_stall", 2'b01, 50, 40, 4, 3,  30, 9,   0, 49, 39, 51, 41);
        run_cmd("clear",     2'b10, 0,  0,  2, 0,  30, 4800, 0, 0,  0,  79, 59);

        // Clear interrupted by reset after 1000 taken writes.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_color = 3'd6;
        t0n = n_taken;
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (n_taken - t0n >= 1000) begin
                hit = 1'b1;
                reset = 1'b1;
                wr_stall = 1'b1;
            end else begin
                wr_stall = ($urandom_range(99) < 30);
            end
        end
        check("rst_mid_reached", hit, 1);
        check("rst_mid_count", n_taken - t0n, 1000);
        @(negedge clk);
        reset = 1'b0;
        wr_stall = 1'b0;
        #2;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_done", done, 0);
        repeat (4) @(negedge clk);
        run_cmd("point_after", 2'b00, 5, 7, 1, 0, 0, 1, 0, 5, 7, 5, 7);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
